// File: rtl/nrf_spi_transaction_if.sv
// Signal bundle between the nRF24L01 transaction sequencer, its host and the byte-level SPI engine.
// The slave modport is the sequencer side; master is the host/engine side.
interface nrf_spi_transaction_if;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [7:0] cmd_opcode;
   logic [5:0] cmd_len;
   logic       wr_en;
   logic [4:0] wr_addr;
   logic [7:0] wr_data;
   logic [4:0] rd_addr;
   logic [7:0] rd_data;
   logic [7:0] status_out;
   logic       busy;
   logic       done;
   logic       error;
   logic       csn;
   logic       byte_start;
   logic [7:0] byte_tx;
   logic       byte_done;
   logic [7:0] byte_rx;

   modport slave (
      input  cmd_valid, cmd_opcode, cmd_len, wr_en, wr_addr, wr_data, rd_addr,
             byte_done, byte_rx,
      output cmd_ready, rd_data, status_out, busy, done, error, csn,
             byte_start, byte_tx
   );

   modport master (
      output cmd_valid, cmd_opcode, cmd_len, wr_en, wr_addr, wr_data, rd_addr,
             byte_done, byte_rx,
      input  cmd_ready, rd_data, status_out, busy, done, error, csn,
             byte_start, byte_tx
   );
endinterface

// File: rtl/nrf_spi_transaction.sv
// Multi-byte nRF24L01 command sequencer: holds CSN low over opcode + payload bytes,
// drives one byte per start/done handshake and captures STATUS plus response bytes.
module nrf_spi_transaction #(
   parameter int CSN_SETUP = 2,
   parameter int CSN_HOLD  = 2,
   parameter int TIMEOUT   = 4096
) (
   input  logic                 clk,
   input  logic                 reset,
   nrf_spi_transaction_if.slave bus
);

   localparam int CNT_MAX = (TIMEOUT > CSN_SETUP) ?
                            ((TIMEOUT > CSN_HOLD) ? TIMEOUT : CSN_HOLD) :
                            ((CSN_SETUP > CSN_HOLD) ? CSN_SETUP : CSN_HOLD);
   localparam int CW = $clog2(CNT_MAX + 1);

   localparam logic [CW-1:0] SETUP_LAST = CW'(CSN_SETUP - 1);
   localparam logic [CW-1:0] HOLD_LAST  = CW'(CSN_HOLD - 1);
   localparam logic [CW-1:0] WD_LAST    = CW'(TIMEOUT - 1);
   localparam logic [5:0]    MAX_LEN    = 6'd32;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SETUP = 3'd1,
      ST_SEND  = 3'd2,
      ST_WAIT  = 3'd3,
      ST_HOLD  = 3'd4,
      ST_DONE  = 3'd5
   } state_t;

   function automatic logic [5:0] clamp_len(input logic [5:0] len);
      if (len > MAX_LEN) begin
         return MAX_LEN;
      end else begin
         return len;
      end
   endfunction

   state_t        state_r, state_s;
   logic [CW-1:0] cnt_r, cnt_s;
   logic [5:0]    idx_r, idx_s;
   logic [5:0]    len_r;
   logic [7:0]    opcode_r;
   logic          accept_s, abort_s, capture_s;
   logic          csn_low_s;
   logic [4:0]    tx_ptr_s;
   logic [7:0]    byte_tx_s;

   logic          csn_r, byte_start_r, done_r, error_r, busy_r, cmd_ready_r;
   logic [7:0]    byte_tx_r, status_r;

   logic [7:0]    pay_mem_r [32];
   logic [7:0]    rsp_mem_r [32];

   // State, shared phase counter and byte index registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= ST_IDLE;
         cnt_r   <= '0;
         idx_r   <= 6'd0;
      end else begin
         state_r <= state_s;
         cnt_r   <= cnt_s;
         idx_r   <= idx_s;
      end
   end

   // Next-state logic; cnt_r times SETUP, HOLD and the WAIT watchdog
   always_comb begin
      state_s   = state_r;
      cnt_s     = cnt_r;
      idx_s     = idx_r;
      accept_s  = 1'b0;
      abort_s   = 1'b0;
      capture_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (bus.cmd_valid && cmd_ready_r) begin
               accept_s = 1'b1;
               state_s  = ST_SETUP;
               cnt_s    = '0;
               idx_s    = 6'd0;
            end else begin
               state_s  = ST_IDLE;
            end
         end
         ST_SETUP: begin
            if (cnt_r == SETUP_LAST) begin
               state_s = ST_SEND;
               cnt_s   = '0;
            end else begin
               cnt_s   = cnt_r + CW'(1);
            end
         end
         ST_SEND: begin
            state_s = ST_WAIT;
            cnt_s   = '0;
         end
         ST_WAIT: begin
            if (bus.byte_done) begin
               capture_s = 1'b1;
               cnt_s     = '0;
               if (idx_r == len_r) begin
                  state_s = ST_HOLD;
               end else begin
                  idx_s   = idx_r + 6'd1;
                  state_s = ST_SEND;
               end
            end else if (cnt_r == WD_LAST) begin
               abort_s = 1'b1;
               state_s = ST_DONE;
               cnt_s   = '0;
            end else begin
               cnt_s   = cnt_r + CW'(1);
            end
         end
         ST_HOLD: begin
            if (cnt_r == HOLD_LAST) begin
               state_s = ST_DONE;
               cnt_s   = '0;
            end else begin
               cnt_s   = cnt_r + CW'(1);
            end
         end
         ST_DONE: begin
            state_s = ST_IDLE;
         end
         default: begin
            state_s = ST_IDLE;
            cnt_s   = '0;
            idx_s   = 6'd0;
         end
      endcase
   end

   // Byte to present on the next SEND: opcode first, then payload[idx-1]
   always_comb begin
      tx_ptr_s  = idx_s[4:0] - 5'd1;
      csn_low_s = (state_s == ST_SETUP) || (state_s == ST_SEND) ||
                  (state_s == ST_WAIT)  || (state_s == ST_HOLD);
      if (idx_s == 6'd0) begin
         byte_tx_s = opcode_r;
      end else begin
         byte_tx_s = pay_mem_r[tx_ptr_s];
      end
   end

   // Registered outputs decoded from the upcoming state, plus command latch and STATUS capture
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         csn_r        <= 1'b1;
         byte_start_r <= 1'b0;
         byte_tx_r    <= 8'h00;
         done_r       <= 1'b0;
         error_r      <= 1'b0;
         status_r     <= 8'h00;
         busy_r       <= 1'b0;
         cmd_ready_r  <= 1'b1;
         opcode_r     <= 8'h00;
         len_r        <= 6'd0;
      end else begin
         csn_r        <= ~csn_low_s;
         byte_start_r <= (state_s == ST_SEND);
         done_r       <= (state_s == ST_DONE);
         busy_r       <= (state_s != ST_IDLE);
         cmd_ready_r  <= (state_s == ST_IDLE);
         if (state_s == ST_SEND) begin
            byte_tx_r <= byte_tx_s;
         end
         if (accept_s) begin
            opcode_r <= bus.cmd_opcode;
            len_r    <= clamp_len(bus.cmd_len);
            error_r  <= 1'b0;
         end else if (abort_s) begin
            error_r  <= 1'b1;
         end
         if (capture_s && (idx_r == 6'd0)) begin
            status_r <= bus.byte_rx;
         end
      end
   end

   // Payload buffer; writes only land while idle so a running command is never disturbed
   always_ff @(posedge clk) begin
      if (bus.wr_en && cmd_ready_r) begin
         pay_mem_r[bus.wr_addr] <= bus.wr_data;
      end
   end

   // Response buffer; byte n after the opcode lands at index n-1
   always_ff @(posedge clk) begin
      if (capture_s && (idx_r != 6'd0)) begin
         rsp_mem_r[idx_r[4:0] - 5'd1] <= bus.byte_rx;
      end
   end

   assign bus.cmd_ready  = cmd_ready_r;
   assign bus.rd_data    = rsp_mem_r[bus.rd_addr];
   assign bus.status_out = status_r;
   assign bus.busy       = busy_r;
   assign bus.done       = done_r;
   assign bus.error      = error_r;
   assign bus.csn        = csn_r;
   assign bus.byte_start = byte_start_r;
   assign bus.byte_tx    = byte_tx_r;

endmodule

// File: tb/tb_nrf_spi_transaction.sv
// Directed bench for nrf_spi_transaction: a byte-engine model answers each byte_start
// three cycles later from a response queue; a monitor records timing and CSN behaviour.
module tb_nrf_spi_transaction;
   localparam int CSN_SETUP = 2;
   localparam int CSN_HOLD  = 2;
   localparam int TIMEOUT   = 4096;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   nrf_spi_transaction_if bif ();

   nrf_spi_transaction #(
      .CSN_SETUP (CSN_SETUP),
      .CSN_HOLD  (CSN_HOLD),
      .TIMEOUT   (TIMEOUT)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bif)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   int cyc = 0, eng_cnt = 0, starts = 0, done_cnt = 0, csn_rise = 0, csn_gap = 0;
   int bd_cyc = 0, start_cyc = 0, done_cyc = 0, first_start_cyc = 0, busy_rise_cyc = 0;
   bit first_pend = 1'b0, eng_en = 1'b1, prev_csn = 1'b1, prev_busy = 1'b0;
   logic [7:0] rxq    [$];
   logic [7:0] tx_log [$];

   // Byte-engine model and monitor, evaluated on the falling edge
   always @(negedge clk) begin
      cyc++;
      bif.byte_done = 1'b0;
      if (bif.done === 1'b1) begin
         done_cnt++;
         done_cyc = cyc;
      end
      if (bif.csn === 1'b1 && prev_csn == 1'b0) csn_rise++;
      if (bif.busy === 1'b1 && bif.csn === 1'b1 && bif.done !== 1'b1) csn_gap++;
      if (bif.busy === 1'b1 && !prev_busy) begin
         busy_rise_cyc = cyc;
         first_pend    = 1'b1;
      end
      prev_csn  = bif.csn;
      prev_busy = bif.busy;
      if (reset) begin
         eng_cnt = 0;
      end else if (bif.byte_start === 1'b1) begin
         starts++;
         start_cyc = cyc;
         tx_log.push_back(bif.byte_tx);
         if (first_pend) begin
            first_start_cyc = cyc;
            first_pend      = 1'b0;
         end
         eng_cnt = 3;
      end else if (eng_cnt > 0) begin
         eng_cnt--;
         if (eng_cnt == 0 && eng_en) begin
            bif.byte_done = 1'b1;
            if (rxq.size() > 0) bif.byte_rx = rxq.pop_front();
            else                bif.byte_rx = 8'h00;
            bd_cyc = cyc;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic start_cmd(input logic [7:0] op, input logic [5:0] len);
      int n;
      n = 0;
      while (bif.cmd_ready !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      bif.cmd_opcode = op;
      bif.cmd_len    = len;
      bif.cmd_valid  = 1'b1;
      tick();
      bif.cmd_valid  = 1'b0;
   endtask

   task automatic wait_done(input int limit);
      int n;
      n = 0;
      while (bif.done !== 1'b1 && n < limit) begin
         tick();
         n++;
      end
      chk("done_seen", 32'(bif.done), 32'd1);
   endtask

   task automatic rd(input logic [4:0] a, output logic [7:0] d);
      bif.rd_addr = a;
      #1;
      d = bif.rd_data;
   endtask

   int s0, d0, r0, g0;
   logic [7:0] rv;

   initial begin
      bif.cmd_valid  = 1'b0;
      bif.cmd_opcode = 8'h00;
      bif.cmd_len    = 6'd0;
      bif.wr_en      = 1'b0;
      bif.wr_addr    = 5'd0;
      bif.wr_data    = 8'h00;
      bif.rd_addr    = 5'd0;
      reset = 1'b1;
      tick();
      tick();
      chk("rst_csn",        32'(bif.csn),        32'd1);
      chk("rst_byte_start", 32'(bif.byte_start), 32'd0);
      chk("rst_byte_tx",    32'(bif.byte_tx),    32'h00);
      chk("rst_done",       32'(bif.done),       32'd0);
      chk("rst_error",      32'(bif.error),      32'd0);
      chk("rst_status",     32'(bif.status_out), 32'h00);
      chk("rst_busy",       32'(bif.busy),       32'd0);
      chk("rst_cmd_ready",  32'(bif.cmd_ready),  32'd1);
      reset = 1'b0;
      tick();

      // reset in the middle of a transfer
      d0 = done_cnt;
      start_cmd(8'h00, 6'd2);
      tick(); tick(); tick();
      chk("mid_csn_low", 32'(bif.csn), 32'd0);
      reset = 1'b1;
      #1;
      chk("mid_rst_csn_async", 32'(bif.csn), 32'd1);
      tick(); tick();
      reset = 1'b0;
      tick(); tick(); tick();
      chk("mid_cmd_ready", 32'(bif.cmd_ready),  32'd1);
      chk("mid_status",    32'(bif.status_out), 32'h00);
      chk("mid_busy",      32'(bif.busy),       32'd0);
      chk("mid_no_done",   32'(done_cnt - d0),  32'd0);

      // R_REGISTER 0x00, one data byte
      bif.wr_en = 1'b1; bif.wr_addr = 5'd0; bif.wr_data = 8'h00;
      tick();
      bif.wr_en = 1'b0;
      rxq.delete(); rxq.push_back(8'h0E); rxq.push_back(8'h08);
      tx_log.delete();
      s0 = starts; d0 = done_cnt; r0 = csn_rise; g0 = csn_gap;
      start_cmd(8'h00, 6'd1);
      wait_done(200);
      chk("t2_error",  32'(bif.error),      32'd0);
      chk("t2_starts", 32'(starts - s0),    32'd2);
      chk("t2_tx0",    32'(tx_log[0]),      32'h00);
      chk("t2_tx1",    32'(tx_log[1]),      32'h00);
      chk("t2_status", 32'(bif.status_out), 32'h0E);
      chk("t2_setup",  32'(first_start_cyc - busy_rise_cyc), 32'(CSN_SETUP));
      rd(5'd0, rv);
      chk("t2_rd0",    32'(rv), 32'h08);
      tick();
      chk("t2_done_cnt", 32'(done_cnt - d0), 32'd1);

      // W_TX_PAYLOAD with a full 32-byte payload
      for (int i = 0; i < 32; i++) begin
         bif.wr_en = 1'b1; bif.wr_addr = 5'(i); bif.wr_data = 8'(i);
         tick();
      end
      bif.wr_en = 1'b0;
      rxq.delete(); rxq.push_back(8'h4E);
      for (int i = 0; i < 32; i++) rxq.push_back(8'(8'h80 + i));
      tx_log.delete();
      s0 = starts; d0 = done_cnt; r0 = csn_rise; g0 = csn_gap;
      start_cmd(8'hA0, 6'd32);
      wait_done(500);
      tick();
      chk("t3_starts",   32'(starts - s0),    32'd33);
      chk("t3_tx_op",    32'(tx_log[0]),      32'hA0);
      for (int i = 0; i < 32; i++) chk("t3_tx_pay", 32'(tx_log[i + 1]), 32'(i));
      chk("t3_csn_rise", 32'(csn_rise - r0),  32'd1);
      chk("t3_csn_gap",  32'(csn_gap - g0),   32'd0);
      chk("t3_done_cnt", 32'(done_cnt - d0),  32'd1);
      chk("t3_status",   32'(bif.status_out), 32'h4E);
      rd(5'd0,  rv); chk("t3_rd0",  32'(rv), 32'h80);
      rd(5'd31, rv); chk("t3_rd31", 32'(rv), 32'h9F);

      // NOP, opcode only
      rxq.delete(); rxq.push_back(8'h2E);
      tx_log.delete();
      s0 = starts;
      start_cmd(8'hFF, 6'd0);
      wait_done(200);
      chk("t4_starts",  32'(starts - s0),      32'd1);
      chk("t4_tx",      32'(tx_log[0]),        32'hFF);
      chk("t4_status",  32'(bif.status_out),   32'h2E);
      chk("t4_latency", 32'(done_cyc - bd_cyc), 32'(CSN_HOLD + 1));
      rd(5'd0, rv); chk("t4_rd0_kept", 32'(rv), 32'h80);

      // engine never answers: watchdog abort
      eng_en = 1'b0;
      s0 = starts;
      start_cmd(8'h61, 6'd1);
      wait_done(TIMEOUT + 100);
      chk("t5_error",   32'(bif.error),           32'd1);
      chk("t5_csn",     32'(bif.csn),             32'd1);
      chk("t5_starts",  32'(starts - s0),         32'd1);
      chk("t5_timeout", 32'(done_cyc - start_cyc), 32'(TIMEOUT + 1));
      eng_en = 1'b1;
      rxq.delete(); rxq.push_back(8'h0E);
      start_cmd(8'hFF, 6'd0);
      chk("t5_err_clear", 32'(bif.error), 32'd0);
      wait_done(200);
      chk("t5_status", 32'(bif.status_out), 32'h0E);

      // length clamp and payload write attempt while busy
      rxq.delete();
      tx_log.delete();
      s0 = starts;
      start_cmd(8'hA0, 6'd40);
      bif.wr_en = 1'b1; bif.wr_addr = 5'd5; bif.wr_data = 8'hEE;
      tick();
      bif.wr_en = 1'b0;
      wait_done(500);
      chk("t6_starts", 32'(starts - s0), 32'd33);
      chk("t6_tx6",    32'(tx_log[6]),   32'h05);
      chk("t6_tx32",   32'(tx_log[32]),  32'h1F);
      tick(); tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "simulation time limit");
   end
endmodule
